// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Opcode constants for the control unit live in the decode package, not here.
package fetch_unit_pkg;

    // Fetch controller states: idle after reset, requesting, holding an
    // instruction for the datapath, and the terminal misaligned-target state.
    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_REQ   = 2'd1,
        FETCH_HOLD  = 2'd2,
        FETCH_FAULT = 2'd3
    } fetch_state_t;

    // Sequential PC increment: one 32-bit instruction word.
    localparam logic [31:0] PC_STEP = 32'd4;

    // Canonical NOP (addi x0, x0, 0), handy for benches and bubble filling.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // True when the address can be used as an instruction fetch address.
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/ready bus between the fetch stage and imem.
// The fetch stage is the master; the memory (or a bench model) is the slave.
interface fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_unit_pc_next_calc.sv
// Next-PC arithmetic for the fetch stage. Purely combinational so that a later
// pipelined PC stage can reuse it without dragging in the fetch controller.
module pc_next_calc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    // Taken branches add the sign-extended byte offset, everything else steps
    // one word; both wrap modulo 2^32, so 0xFFFF_FFFC + 4 lands on zero.
    assign next_pc    = branch_taken ? (pc + branch_offset) : (pc + PC_STEP);

    // Any target that is not word aligned cannot be fetched.
    assign misaligned = !is_word_aligned(next_pc);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage for the single-cycle RISC-V core.
// Owns the PC, requests words from instruction memory, holds each fetched
// instruction until the datapath retires it, then steps or branches the PC.
// Every output is a flop or the PC register itself, so nothing reaches an
// output combinationally from an input.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic                clk,
    input  logic                rst,
    fetch_unit_if.master        imem,
    output logic                instr_valid,
    output logic [31:0]         instruction,
    output logic [31:0]         pc,
    input  logic                instr_ack,
    input  logic                branch_taken,
    input  logic [31:0]         branch_offset,
    output logic                fetch_fault,
    output logic [31:0]         retired_count
);

    fetch_state_t state;
    logic         req_q;
    logic [31:0]  next_pc;
    logic         next_misaligned;

    pc_next_calc u_pc_next_calc (
        .pc            (pc),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .next_pc       (next_pc),
        .misaligned    (next_misaligned)
    );

    // The request address is the PC register; it only moves on a retire in
    // HOLD, so it stays stable for the whole time the request is raised.
    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc;

    // Fetch controller: state, registered handshake flags, PC, held
    // instruction and retire counter all move together on the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= FETCH_IDLE;
            req_q         <= 1'b0;
            instr_valid   <= 1'b0;
            instruction   <= 32'h0;
            pc            <= RESET_PC;
            fetch_fault   <= 1'b0;
            retired_count <= 32'h0;
        end else begin
            case (state)
                FETCH_IDLE: begin
                    state       <= FETCH_REQ;
                    req_q       <= 1'b1;
                    instr_valid <= 1'b0;
                end

                FETCH_REQ: begin
                    if (imem.imem_ready) begin
                        instruction <= imem.imem_rdata;
                        state       <= FETCH_HOLD;
                        req_q       <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end

                FETCH_HOLD: begin
                    if (instr_ack) begin
                        retired_count <= retired_count + 32'd1;
                        pc            <= next_pc;
                        instr_valid   <= 1'b0;
                        if (next_misaligned) begin
                            fetch_fault <= 1'b1;
                            state       <= FETCH_FAULT;
                            req_q       <= 1'b0;
                        end else begin
                            state       <= FETCH_REQ;
                            req_q       <= 1'b1;
                        end
                    end
                end

                FETCH_FAULT: begin
                    req_q       <= 1'b0;
                    instr_valid <= 1'b0;
                end

                default: begin
                    state       <= FETCH_IDLE;
                    req_q       <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios for reset, wait
// states, branches, faults, spurious inputs and async reset, followed by a
// randomized run against a transaction-level model of the fetch stream.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] BOOT_PC = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        instr_ack;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        fetch_fault;
    logic [31:0] retired_count;

    fetch_unit_if mem ();

    fetch_unit #(.RESET_PC(BOOT_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem          (mem),
        .instr_valid   (instr_valid),
        .instruction   (instruction),
        .pc            (pc),
        .instr_ack     (instr_ack),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .fetch_fault   (fetch_fault),
        .retired_count (retired_count)
    );

    // 10 ns free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compare_count  = 0;
    int mismatch_count = 0;

    // Model of the architectural fetch stream: where the next fetch must go,
    // how many instructions have retired, whether a fault has been latched.
    logic [31:0] model_pc;
    int unsigned model_count;
    bit          model_fault;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req"},   {31'h0, mem.imem_req}, 32'h0);
        checkOutput({tag, "_addr"},  mem.imem_addr, BOOT_PC);
        checkOutput({tag, "_pc"},    pc, BOOT_PC);
        checkOutput({tag, "_valid"}, {31'h0, instr_valid}, 32'h0);
        checkOutput({tag, "_instr"}, instruction, 32'h0);
        checkOutput({tag, "_fault"}, {31'h0, fetch_fault}, 32'h0);
        checkOutput({tag, "_count"}, retired_count, 32'h0);
    endtask

    task automatic quietInputs();
        mem.imem_ready = 1'b0;
        mem.imem_rdata = 32'h0;
        instr_ack      = 1'b0;
        branch_taken   = 1'b0;
        branch_offset  = 32'h0;
    endtask

    // Synchronous-looking reset from a falling edge; leaves DUT in its first
    // fetch cycle at the next falling edge.
    task automatic resetDut();
        quietInputs();
        rst = 1'b1;
        #1;
        checkResetValues("rst");
        @(negedge clk);
        rst = 1'b0;
        model_pc    = BOOT_PC;
        model_count = 0;
        model_fault = 0;
        checkOutput("idle_req", {31'h0, mem.imem_req}, 32'h0);
        stepCycle();
    endtask

    // Raise reset between clock edges and confirm outputs clear at once.
    task automatic asyncResetCheck(input string tag);
        #2;
        rst = 1'b1;
        #1;
        checkResetValues(tag);
        @(negedge clk);
        quietInputs();
        rst = 1'b0;
        model_pc    = BOOT_PC;
        model_count = 0;
        model_fault = 0;
        stepCycle();
    endtask

    // One full instruction: wait states, ready cycle, extra hold cycles with
    // spurious ready pulses, then a retire with the given branch decision.
    // Entered and left on a falling edge with the DUT requesting.
    task automatic applyStimulus(input int wait_cycles, input int hold_cycles,
                                 input logic taken, input logic [31:0] offset,
                                 input logic [31:0] word, input bit spurious_ack);
        logic [31:0] target;
        for (int i = 0; i < wait_cycles; i++) begin
            checkOutput("wait_req",   {31'h0, mem.imem_req}, 32'h1);
            checkOutput("wait_addr",  mem.imem_addr, model_pc);
            checkOutput("wait_valid", {31'h0, instr_valid}, 32'h0);
            checkOutput("wait_count", retired_count, model_count);
            mem.imem_ready = 1'b0;
            mem.imem_rdata = $urandom;
            instr_ack      = spurious_ack;
            branch_taken   = 1'($urandom_range(0, 1));
            branch_offset  = $urandom;
            stepCycle();
        end
        checkOutput("fetch_req",   {31'h0, mem.imem_req}, 32'h1);
        checkOutput("fetch_addr",  mem.imem_addr, model_pc);
        checkOutput("fetch_pc",    pc, model_pc);
        checkOutput("fetch_count", retired_count, model_count);
        mem.imem_ready = 1'b1;
        mem.imem_rdata = word;
        instr_ack      = spurious_ack;
        stepCycle();
        mem.imem_ready = 1'b0;
        instr_ack      = 1'b0;
        for (int i = 0; i < hold_cycles; i++) begin
            checkOutput("hold_valid", {31'h0, instr_valid}, 32'h1);
            checkOutput("hold_req",   {31'h0, mem.imem_req}, 32'h0);
            checkOutput("hold_instr", instruction, word);
            mem.imem_ready = 1'($urandom_range(0, 1));
            mem.imem_rdata = $urandom;
            branch_taken   = 1'($urandom_range(0, 1));
            branch_offset  = $urandom;
            stepCycle();
        end
        mem.imem_ready = 1'b0;
        checkOutput("ret_valid", {31'h0, instr_valid}, 32'h1);
        checkOutput("ret_req",   {31'h0, mem.imem_req}, 32'h0);
        checkOutput("ret_instr", instruction, word);
        checkOutput("ret_pc",    pc, model_pc);
        instr_ack     = 1'b1;
        branch_taken  = taken;
        branch_offset = offset;
        stepCycle();
        quietInputs();

        target      = taken ? (model_pc + offset) : (model_pc + 32'd4);
        model_pc    = target;
        model_count = model_count + 1;
        checkOutput("post_count", retired_count, 32'(model_count));
        checkOutput("post_pc",    pc, model_pc);

        if (target % 4 != 0) begin
            model_fault = 1;
            for (int i = 0; i < 10; i++) begin
                checkOutput("fault_flag",  {31'h0, fetch_fault}, 32'h1);
                checkOutput("fault_req",   {31'h0, mem.imem_req}, 32'h0);
                checkOutput("fault_valid", {31'h0, instr_valid}, 32'h0);
                checkOutput("fault_pc",    pc, model_pc);
                checkOutput("fault_count", retired_count, 32'(model_count));
                mem.imem_ready = 1'($urandom_range(0, 1));
                instr_ack      = 1'($urandom_range(0, 1));
                stepCycle();
            end
            quietInputs();
        end else begin
            checkOutput("next_req",   {31'h0, mem.imem_req}, 32'h1);
            checkOutput("next_valid", {31'h0, instr_valid}, 32'h0);
            checkOutput("next_fault", {31'h0, fetch_fault}, 32'h0);
        end
    endtask

    // Retire one instruction as a taken branch landing on an aligned target.
    task automatic gotoPc(input logic [31:0] target);
        applyStimulus(0, 0, 1'b1, target - model_pc, NOP_INSTR, 1'b0);
    endtask

    initial begin
        logic [31:0] offset;
        logic        taken;
        rst = 1'b1;
        quietInputs();
        model_pc    = BOOT_PC;
        model_count = 0;
        model_fault = 0;
        @(negedge clk);

        $display("[TB] reset and zero-wait stream");
        resetDut();
        for (int i = 0; i < 3; i++) begin
            checkOutput("seq_addr", mem.imem_addr, BOOT_PC + 32'(4 * i));
            applyStimulus(0, 0, 1'b0, 32'h0, $urandom, 1'b0);
        end
        checkOutput("seq_count3", retired_count, 32'd3);

        $display("[TB] three wait states with spurious ack");
        applyStimulus(3, 0, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b1);

        $display("[TB] branches around 0x200");
        gotoPc(32'h200);
        applyStimulus(0, 1, 1'b1, 32'hFFFF_FFF8, 32'h0000_0063, 1'b0);
        checkOutput("br_taken_addr", mem.imem_addr, 32'h1F8);
        gotoPc(32'h200);
        applyStimulus(0, 2, 1'b0, 32'hFFFF_FFF8, 32'h0000_0063, 1'b0);
        checkOutput("br_nt_addr", mem.imem_addr, 32'h204);

        $display("[TB] pc wrap");
        gotoPc(32'hFFFF_FFFC);
        applyStimulus(1, 0, 1'b0, 32'h0, NOP_INSTR, 1'b0);
        checkOutput("wrap_addr", mem.imem_addr, 32'h0);

        $display("[TB] misaligned branch target");
        gotoPc(32'h40);
        applyStimulus(0, 0, 1'b1, 32'h6, 32'h0000_0063, 1'b0);
        checkOutput("mis_pc", pc, 32'h46);

        $display("[TB] async reset mid-fetch");
        resetDut();
        applyStimulus(0, 0, 1'b0, 32'h0, NOP_INSTR, 1'b0);
        mem.imem_ready = 1'b0;
        stepCycle();
        asyncResetCheck("arst_fetch");
        checkOutput("arst_fetch_restart", mem.imem_addr, BOOT_PC);
        checkOutput("arst_fetch_req", {31'h0, mem.imem_req}, 32'h1);

        $display("[TB] async reset mid-hold");
        applyStimulus(0, 0, 1'b0, 32'h0, NOP_INSTR, 1'b0);
        mem.imem_ready = 1'b1;
        mem.imem_rdata = 32'h1234_5678;
        stepCycle();
        mem.imem_ready = 1'b0;
        checkOutput("pre_arst_valid", {31'h0, instr_valid}, 32'h1);
        instr_ack = 1'b0;
        asyncResetCheck("arst_hold");
        checkOutput("arst_hold_restart", mem.imem_addr, BOOT_PC);

        $display("[TB] randomized stream");
        for (int n = 0; n < 300; n++) begin
            taken  = 1'($urandom_range(0, 1));
            offset = 32'(($urandom_range(0, 127) - 64) * 4);
            if ($urandom_range(0, 15) == 0)
                offset = offset + 32'($urandom_range(1, 3));
            applyStimulus($urandom_range(0, 3), $urandom_range(0, 2), taken, offset,
                          $urandom, 1'($urandom_range(0, 1)));
            if (model_fault)
                resetDut();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the single-cycle RISC-V core. It owns the program counter and issues word requests to instruction memory over a request/ready handshake. It holds each returned instruction stable for the decode/control stage until the datapath retires it, then steps the PC by 4 or to the taken-branch target. The instruction it presents is the source of the opcode field `instruction[6:0]` consumed by the control unit.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  word address of the request; equals pc.
- imem_ready  in  1  memory has imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word from memory.
- instr_valid  out  1  instruction/pc outputs hold a valid, unretired instruction.
- instruction  out  32  fetched instruction; bits [6:0] are the control-unit opcode.
- pc  out  32  address of the presented instruction.
- instr_ack  in  1  datapath retires the presented instruction this cycle.
- branch_taken  in  1  retiring instruction is a taken branch (branch & zero).
- branch_offset  in  32  sign-extended byte offset from the immediate generator.
- fetch_fault  out  1  sticky: a misaligned next-PC was computed.
- retired_count  out  32  count of retired instructions; wraps modulo 2^32.

## Operation
- States: IDLE, FETCH, HOLD, FAULT.
- IDLE: entered on reset; unconditionally goes to FETCH on the next edge.
- FETCH: imem_req=1 and imem_addr=pc. On imem_ready=1, capture imem_rdata into instruction and go to HOLD. Otherwise stay.
- HOLD: instr_valid=1 and imem_req=0.
  - On instr_ack=1, compute next_pc = branch_taken ? pc + branch_offset : pc + 4, using 32-bit wrap-around addition.
  - retired_count increments on that ack.
  - If next_pc[1:0]==0: load pc and go to FETCH.
  - Else: load pc with next_pc, set fetch_fault, and go to FAULT.
- FAULT: imem_req=0 and instr_valid=0. Remains until rst; pc holds the offending target.
- branch_taken and branch_offset are sampled only on the edge where instr_valid & instr_ack.
- instr_ack while instr_valid=0 is ignored: no pc change, no count.
- imem_ready outside FETCH is ignored; imem_rdata is not sampled.
- PC wrap: pc + 4 from 32'hFFFF_FFFC gives 32'h0000_0000. This is legal, not a fault.

## Timing
- Reset values:
  - pc=RESET_PC, instruction=32'h0, state=IDLE.
  - imem_req=0, instr_valid=0, fetch_fault=0, retired_count=0.
  - instruction=0 decodes to all-zero control signals.
- All outputs are registered or decoded from the state register only. There are no combinational paths from inputs to outputs.
- imem_ready may be high in the first FETCH cycle (zero-wait memory).
- Best-case throughput is 2 cycles per instruction: FETCH then HOLD, with instr_ack high in the first HOLD cycle.
- imem_addr is stable for as long as imem_req is high.
- Reset mid-FETCH abandons the request. imem_req drops asynchronously with rst, and memory must tolerate the withdrawn request.
- Reset mid-HOLD discards the instruction. No retire is counted.

## Structure
- Shared defines header gets:
  - the fetch state encodings (2-bit FETCH_IDLE/FETCH_REQ/FETCH_HOLD/FETCH_FAULT);
  - `PC_STEP = 32'd4;
  - `NOP_INSTR = 32'h0000_0013 for bench use.
- Opcode constants stay where they already are.
- One sub-module: `pc_next_calc`. It is combinational and produces next_pc and a misaligned flag from pc, branch_taken and branch_offset. It is reusable by a later pipelined PC stage.

## Test plan
- Reset with RESET_PC=32'h100, zero-wait memory, ack every HOLD cycle:
  - Outputs during reset are all zero except pc=32'h100.
  - After release, imem_addr sequence is 100, 104, 108.
  - instr_valid toggles 0/1, and retired_count reaches 3 after three HOLD cycles.
- Memory with 3 wait cycles (ready low then high):
  - imem_req is held high with imem_addr constant for 4 cycles.
  - instruction captures the rdata present on the ready cycle only.
- Taken branch at pc=32'h200 with branch_offset=32'hFFFF_FFF8 -> next fetch at 32'h1F8. Same with branch_taken=0 -> next fetch at 32'h204.
- Misaligned target: branch_offset=32'h6 at pc=32'h40 ->
  - fetch_fault=1 and pc=32'h46;
  - imem_req stays 0 and instr_valid stays 0 for 10 cycles;
  - retired_count has incremented by 1.
- Spurious inputs:
  - instr_ack held high during FETCH does not change pc or count;
  - imem_ready pulsed during HOLD does not change instruction.
- rst asserted mid-FETCH and mid-HOLD -> all outputs return to reset values immediately (asynchronously), and the fetch sequence restarts from RESET_PC.
